// File: rtl/spr_dma_ctrl.sv
// Sprite DMA controller: snoops CPU writes to the DMA register, halts the CPU,
// then copies 256 bytes from {page,00..FF} to the PPU sprite RAM data register.
`timescale 1ns/1ps
module spr_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        cpu_cyc_in,
   input  logic [15:0] cpu_a_in,
   input  logic        cpu_r_nw_in,
   input  logic [7:0]  cpu_d_in,
   input  logic [7:0]  mem_d_in,
   output logic        rdy_out,
   output logic        active_out,
   output logic [15:0] a_out,
   output logic [7:0]  d_out,
   output logic        r_nw_out
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SYNC  = 2'd1,
      S_READ  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   page_q,  page_d;
   logic [DW-1:0]   count_q, count_d;
   logic [DW-1:0]   data_q,  data_d;

   logic            rdy_q,    rdy_d;
   logic            active_q, active_d;
   logic [AW-1:0]   a_q,      a_d;
   logic [DW-1:0]   d_q,      d_d;
   logic            r_nw_q,   r_nw_d;

   // Next-state logic: advances only on edges that complete a CPU bus cycle.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      count_d = count_q;
      data_d  = data_q;
      if (cpu_cyc_in) begin
         case (state_q)
            S_IDLE: begin
               if (cpu_a_in == DMA_REG_ADDR && !cpu_r_nw_in) begin
                  page_d  = cpu_d_in;
                  count_d = 8'h00;
                  state_d = S_SYNC;
               end
            end
            S_SYNC: state_d = S_READ;
            S_READ: begin
               data_d  = mem_d_in;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               if (count_q == 8'hFF) begin
                  state_d = S_IDLE;
               end else begin
                  count_d = count_q + 8'd1;
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output decode from next-cycle state so the bus outputs can be registered.
   always_comb begin
      rdy_d    = 1'b1;
      active_d = 1'b0;
      a_d      = 16'h0000;
      d_d      = 8'h00;
      r_nw_d   = 1'b1;
      case (state_d)
         S_SYNC: begin
            rdy_d    = 1'b0;
            active_d = 1'b1;
         end
         S_READ: begin
            rdy_d    = 1'b0;
            active_d = 1'b1;
            a_d      = {page_d, count_d};
         end
         S_WRITE: begin
            rdy_d    = 1'b0;
            active_d = 1'b1;
            a_d      = OAM_DATA_ADDR;
            d_d      = data_d;
            r_nw_d   = 1'b0;
         end
         default: ;
      endcase
   end

   // State, transfer context and output registers; reset abandons any transfer.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         page_q   <= 8'h00;
         count_q  <= 8'h00;
         data_q   <= 8'h00;
         rdy_q    <= 1'b1;
         active_q <= 1'b0;
         a_q      <= 16'h0000;
         d_q      <= 8'h00;
         r_nw_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         count_q  <= count_d;
         data_q   <= data_d;
         rdy_q    <= rdy_d;
         active_q <= active_d;
         a_q      <= a_d;
         d_q      <= d_d;
         r_nw_q   <= r_nw_d;
      end
   end

   assign rdy_out    = rdy_q;
   assign active_out = active_q;
   assign a_out      = a_q;
   assign d_out      = d_q;
   assign r_nw_out   = r_nw_q;

endmodule

// File: tb/tb_spr_dma_ctrl.sv
// Bench for spr_dma_ctrl: directed steps, scoreboard of expected DMA bus cycles.
`timescale 1ns/1ps
module tb_spr_dma_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        cpu_cyc_in;
   logic [15:0] cpu_a_in;
   logic        cpu_r_nw_in;
   logic [7:0]  cpu_d_in;
   logic [7:0]  mem_d_in;
   logic        rdy_out;
   logic        active_out;
   logic [15:0] a_out;
   logic [7:0]  d_out;
   logic        r_nw_out;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
      logic        rnw;
   } bus_t;

   bus_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   low_cnt = 0;
   int   wr_cnt = 0;

   bus_t prev_bus;
   logic prev_cyc = 1'b0;
   logic prev_valid = 1'b0;

   spr_dma_ctrl dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .cpu_cyc_in  (cpu_cyc_in),
      .cpu_a_in    (cpu_a_in),
      .cpu_r_nw_in (cpu_r_nw_in),
      .cpu_d_in    (cpu_d_in),
      .mem_d_in    (mem_d_in),
      .rdy_out     (rdy_out),
      .active_out  (active_out),
      .a_out       (a_out),
      .d_out       (d_out),
      .r_nw_out    (r_nw_out)
   );

   always #5 clk_in = ~clk_in;

   // Memory returns the low byte of the address being read.
   assign mem_d_in = a_out[7:0];

   // Monitor: pop and compare each completed DMA bus cycle; check bus is frozen otherwise.
   always @(negedge clk_in) begin
      bus_t obs;
      bus_t e;
      obs.a   = a_out;
      obs.d   = d_out;
      obs.rnw = r_nw_out;
      if (rst_in) begin
         prev_valid <= 1'b0;
      end else begin
         if (prev_valid && !prev_cyc) begin
            checks++;
            assert (obs === prev_bus) else begin
               errors++;
               $error("FAIL frozen observed %h expected %h", obs, prev_bus);
            end
         end
         if (cpu_cyc_in && active_out) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $error("FAIL extra_cycle observed %h expected none", obs);
            end else begin
               e = exp_q.pop_front();
               assert (obs === e) else begin
                  errors++;
                  $error("FAIL bus observed %h expected %h", obs, e);
               end
            end
            if (!rdy_out)  low_cnt++;
            if (!r_nw_out) wr_cnt++;
         end
         prev_valid <= 1'b1;
      end
      prev_bus <= obs;
      prev_cyc <= cpu_cyc_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected bus cycles for the first n pulses of a transfer from page pg.
   task automatic push_xfer(input logic [7:0] pg, input int n);
      bus_t b;
      for (int k = 0; k < n; k++) begin
         if (k == 0) begin
            b = '{a: 16'h0000, d: 8'h00, rnw: 1'b1};
         end else if (((k - 1) % 2) == 0) begin
            b = '{a: {pg, 8'((k - 1) / 2)}, d: 8'h00, rnw: 1'b1};
         end else begin
            b = '{a: 16'h2004, d: 8'((k - 1) / 2), rnw: 1'b0};
         end
         exp_q.push_back(b);
      end
   endtask

   // One CPU cycle pulse; called and returns at posedge+1.
   task automatic pulse(input logic [15:0] a, input logic rnw, input logic [7:0] d, input int gap);
      cpu_cyc_in  = 1'b1;
      cpu_a_in    = a;
      cpu_r_nw_in = rnw;
      cpu_d_in    = d;
      @(posedge clk_in); #1;
      cpu_cyc_in  = 1'b0;
      cpu_a_in    = 16'h0000;
      cpu_r_nw_in = 1'b1;
      cpu_d_in    = 8'h00;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk_in); #1;
      end
   endtask

   task automatic run(input int n, input int gap);
      for (int i = 0; i < n; i++) pulse(16'h0000, 1'b1, 8'h00, gap);
   endtask

   initial begin
      int lc0;
      int wc0;
      rst_in      = 1'b1;
      cpu_cyc_in  = 1'b0;
      cpu_a_in    = 16'h0000;
      cpu_r_nw_in = 1'b1;
      cpu_d_in    = 8'h00;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_rdy",    32'(rdy_out),    32'd1);
      chk("rst_active", 32'(active_out), 32'd0);
      chk("rst_a",      32'(a_out),      32'h0000);
      chk("rst_d",      32'(d_out),      32'h00);
      chk("rst_rnw",    32'(r_nw_out),   32'd1);
      rst_in = 1'b0;
      @(posedge clk_in); #1;

      // Full transfer from page 02, pulse every clock.
      push_xfer(8'h02, 513);
      lc0 = low_cnt; wc0 = wr_cnt;
      pulse(16'h4014, 1'b0, 8'h02, 0);
      chk("trig_active", 32'(active_out), 32'd1);
      chk("trig_rdy",    32'(rdy_out),    32'd0);
      run(513, 0);
      chk("x1_done_rdy", 32'(rdy_out), 32'd1);
      chk("x1_q_empty",  32'(exp_q.size()), 32'd0);
      chk("x1_low_cnt",  32'(low_cnt - lc0), 32'd513);
      chk("x1_wr_cnt",   32'(wr_cnt - wc0),  32'd256);

      // Same transfer with a pulse every third clock.
      push_xfer(8'h02, 513);
      lc0 = low_cnt;
      pulse(16'h4014, 1'b0, 8'h02, 2);
      run(513, 2);
      chk("x2_q_empty", 32'(exp_q.size()), 32'd0);
      chk("x2_low_cnt", 32'(low_cnt - lc0), 32'd513);
      chk("x2_rdy",     32'(rdy_out), 32'd1);

      // Read of the DMA register and write to a neighbour do not trigger.
      pulse(16'h4014, 1'b1, 8'h05, 1);
      chk("rd4014_rdy",    32'(rdy_out),    32'd1);
      chk("rd4014_active", 32'(active_out), 32'd0);
      pulse(16'h4015, 1'b0, 8'h05, 1);
      chk("wr4015_rdy",    32'(rdy_out),    32'd1);
      chk("wr4015_active", 32'(active_out), 32'd0);

      // Retrigger during READ of count 10 is ignored.
      push_xfer(8'h02, 513);
      pulse(16'h4014, 1'b0, 8'h02, 0);
      run(33, 0);
      chk("retrig_a_before", 32'(a_out), 32'h0210);
      pulse(16'h4014, 1'b0, 8'h07, 0);
      run(479, 0);
      chk("retrig_q_empty", 32'(exp_q.size()), 32'd0);
      chk("retrig_rdy",     32'(rdy_out), 32'd1);

      // Asynchronous reset in WRITE of count 80 aborts the transfer.
      push_xfer(8'h02, 258);
      pulse(16'h4014, 1'b0, 8'h02, 0);
      run(258, 0);
      chk("abort_pre_rnw", 32'(r_nw_out), 32'd0);
      chk("abort_pre_a",   32'(a_out),    32'h2004);
      chk("abort_pre_d",   32'(d_out),    32'h80);
      #2 rst_in = 1'b1;
      #1;
      chk("abort_rdy",    32'(rdy_out),    32'd1);
      chk("abort_active", 32'(active_out), 32'd0);
      chk("abort_a",      32'(a_out),      32'h0000);
      chk("abort_d",      32'(d_out),      32'h00);
      chk("abort_rnw",    32'(r_nw_out),   32'd1);
      @(posedge clk_in); @(posedge clk_in); #1;
      rst_in = 1'b0;
      wc0 = wr_cnt;
      run(20, 0);
      chk("abort_no_resume", 32'(wr_cnt - wc0), 32'd0);
      chk("abort_rdy_idle",  32'(rdy_out), 32'd1);
      chk("abort_q_empty",   32'(exp_q.size()), 32'd0);

      // Back-to-back transfers: retrigger on the first pulse after completion.
      push_xfer(8'h03, 513);
      push_xfer(8'h04, 513);
      lc0 = low_cnt;
      pulse(16'h4014, 1'b0, 8'h03, 0);
      run(513, 0);
      chk("b2b_mid_rdy", 32'(rdy_out), 32'd1);
      pulse(16'h4014, 1'b0, 8'h04, 0);
      chk("b2b_active", 32'(active_out), 32'd1);
      run(513, 0);
      chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);
      chk("b2b_low_cnt", 32'(low_cnt - lc0), 32'd1026);
      chk("b2b_rdy",     32'(rdy_out), 32'd1);

      repeat (2) @(posedge clk_in);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
